// File: rtl/tmr_ctrl_pkg.sv
// Shared types and register mode encodings for the TMR shift-register controller.
package tmr_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TX_LOAD  = 3'd1,
      TX_SHIFT = 3'd2,
      RX_SHIFT = 3'd3,
      RX_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] MODE_SISO_R = 2'b00;
   localparam logic [1:0] MODE_SISO_L = 2'b01;
   localparam logic [1:0] MODE_PISO   = 2'b10;
   localparam logic [1:0] MODE_PIPO   = 2'b11;

endpackage

// File: rtl/fault_counter.sv
// Saturating count of cycles flagged by any replica fault; clear beats increment.
module fault_counter #(
   parameter int unsigned cnt_width = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 clr,
   output logic [cnt_width-1:0] count
);

   localparam logic [cnt_width-1:0] CNT_MAX = '1;

   logic [cnt_width-1:0] count_q;
   logic [cnt_width-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + cnt_width'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/tmr_shift_ctrl.sv
// Sequencer for the TMR shift register: serialises tx words (PISO), captures rx
// words (SISO-right) and tracks replica faults.
module tmr_shift_ctrl
   import tmr_ctrl_pkg::*;
#(
   parameter int unsigned width     = 64,
   parameter int unsigned cnt_width = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic [width-1:0]     tx_data,
   output logic                 tx_bit_valid,
   input  logic                 rx_req,
   output logic                 rx_bit_strobe,
   output logic                 rx_valid,
   output logic [width-1:0]     rx_data,
   input  logic [width-1:0]     reg_parallel_out,
   input  logic                 fault_1,
   input  logic                 fault_2,
   input  logic                 fault_3,
   output logic                 reg_enable,
   output logic                 reg_load,
   output logic [1:0]           reg_mode,
   output logic [width-1:0]     reg_parallel_in,
   output logic                 busy,
   output logic [cnt_width-1:0] fault_count,
   input  logic                 fault_count_clr
);

   localparam int unsigned   CNT_W    = (width > 1) ? $clog2(width) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [width-1:0]   par_in_q, par_in_d;
   logic [width-1:0]   rx_data_q, rx_data_d;

   logic               tx_ready_q, tx_ready_d;
   logic               tx_bit_valid_q, tx_bit_valid_d;
   logic               rx_bit_strobe_q, rx_bit_strobe_d;
   logic               rx_valid_q, rx_valid_d;
   logic               reg_enable_q, reg_enable_d;
   logic               reg_load_q, reg_load_d;
   logic [1:0]         reg_mode_q, reg_mode_d;
   logic               busy_q, busy_d;

   logic               fault_any;

   // Next state and datapath; outputs are decoded from the next state so the
   // registered outputs line up with the state they describe.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      par_in_d  = par_in_q;
      rx_data_d = rx_data_q;

      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            if (tx_ready_q) begin
               if (tx_valid) begin
                  par_in_d = tx_data;
                  state_d  = TX_LOAD;
               end else if (rx_req) begin
                  state_d = RX_SHIFT;
               end
            end
         end
         TX_LOAD: begin
            bit_cnt_d = '0;
            state_d   = TX_SHIFT;
         end
         TX_SHIFT: begin
            if (bit_cnt_q == LAST_BIT) begin
               state_d = IDLE;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         RX_SHIFT: begin
            if (bit_cnt_q == LAST_BIT) begin
               state_d = RX_DONE;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         RX_DONE: begin
            rx_data_d = reg_parallel_out;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      tx_ready_d      = 1'b0;
      tx_bit_valid_d  = 1'b0;
      rx_bit_strobe_d = 1'b0;
      rx_valid_d      = 1'b0;
      reg_enable_d    = 1'b0;
      reg_load_d      = 1'b0;
      reg_mode_d      = MODE_PIPO;
      busy_d          = (state_d != IDLE);

      case (state_d)
         IDLE: begin
            tx_ready_d = 1'b1;
         end
         TX_LOAD: begin
            reg_mode_d   = MODE_PISO;
            reg_load_d   = 1'b1;
            reg_enable_d = 1'b1;
         end
         TX_SHIFT: begin
            reg_mode_d     = MODE_PISO;
            reg_enable_d   = 1'b1;
            tx_bit_valid_d = 1'b1;
         end
         RX_SHIFT: begin
            reg_mode_d      = MODE_SISO_R;
            reg_enable_d    = 1'b1;
            rx_bit_strobe_d = 1'b1;
         end
         RX_DONE: begin
            rx_valid_d = 1'b1;
         end
         default: begin
            tx_ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         bit_cnt_q       <= '0;
         par_in_q        <= '0;
         rx_data_q       <= '0;
         tx_ready_q      <= 1'b0;
         tx_bit_valid_q  <= 1'b0;
         rx_bit_strobe_q <= 1'b0;
         rx_valid_q      <= 1'b0;
         reg_enable_q    <= 1'b0;
         reg_load_q      <= 1'b0;
         reg_mode_q      <= MODE_PIPO;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         bit_cnt_q       <= bit_cnt_d;
         par_in_q        <= par_in_d;
         rx_data_q       <= rx_data_d;
         tx_ready_q      <= tx_ready_d;
         tx_bit_valid_q  <= tx_bit_valid_d;
         rx_bit_strobe_q <= rx_bit_strobe_d;
         rx_valid_q      <= rx_valid_d;
         reg_enable_q    <= reg_enable_d;
         reg_load_q      <= reg_load_d;
         reg_mode_q      <= reg_mode_d;
         busy_q          <= busy_d;
      end
   end

   // The last serial bit lands in the register on the edge that enters RX_DONE,
   // so the word is passed through in that cycle and held afterwards.
   assign rx_data = (state_q == RX_DONE) ? reg_parallel_out : rx_data_q;

   assign tx_ready        = tx_ready_q;
   assign tx_bit_valid    = tx_bit_valid_q;
   assign rx_bit_strobe   = rx_bit_strobe_q;
   assign rx_valid        = rx_valid_q;
   assign reg_enable      = reg_enable_q;
   assign reg_load        = reg_load_q;
   assign reg_mode        = reg_mode_q;
   assign reg_parallel_in = par_in_q;
   assign busy            = busy_q;

   assign fault_any = fault_1 | fault_2 | fault_3;

   fault_counter #(
      .cnt_width(cnt_width)
   ) u_fault_counter (
      .clk  (clk),
      .rst  (rst),
      .inc  (fault_any),
      .clr  (fault_count_clr),
      .count(fault_count)
   );

endmodule

// File: tb/tb_tmr_shift_ctrl.sv
// Directed bench for tmr_shift_ctrl with a behavioural TMR shift register attached.
module tb_tmr_shift_ctrl;

   localparam int unsigned W = 64;

   localparam logic [W-1:0] TXW    = 64'hA5A5_0000_FFFF_1234;
   localparam logic [W-1:0] RXW    = 64'h0123_4567_89AB_CDEF;
   localparam logic [W-1:0] ARB_TX = 64'hDEAD_BEEF_0F0F_8001;
   localparam logic [W-1:0] ARB_RX = 64'h8000_0000_0000_0001;
   localparam logic [W-1:0] B0     = 64'hFFFF_0000_AAAA_5555;
   localparam logic [W-1:0] B1     = 64'h1357_9BDF_2468_ACE0;

   logic          clk, rst;
   logic          tx_valid, tx_ready, tx_bit_valid;
   logic [W-1:0]  tx_data;
   logic          rx_req, rx_bit_strobe, rx_valid;
   logic [W-1:0]  rx_data;
   logic [W-1:0]  reg_parallel_out, reg_parallel_in;
   logic          fault_1, fault_2, fault_3, fault_count_clr;
   logic          reg_enable, reg_load, busy;
   logic [1:0]    reg_mode;
   logic [15:0]   fault_count;
   logic          serial_in, serial_out;
   logic [W-1:0]  reg_q;

   logic          d3_tx_ready, d3_tx_bit_valid, d3_rx_bit_strobe, d3_rx_valid;
   logic [W-1:0]  d3_rx_data, d3_reg_parallel_in;
   logic          d3_reg_enable, d3_reg_load, d3_busy;
   logic [1:0]    d3_reg_mode;
   logic [2:0]    d3_fault_count;

   int checks = 0;
   int errors = 0;

   tmr_shift_ctrl #(.width(W), .cnt_width(16)) u_dut (
      .clk(clk), .rst(rst),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .tx_bit_valid(tx_bit_valid),
      .rx_req(rx_req), .rx_bit_strobe(rx_bit_strobe), .rx_valid(rx_valid), .rx_data(rx_data),
      .reg_parallel_out(reg_parallel_out),
      .fault_1(fault_1), .fault_2(fault_2), .fault_3(fault_3),
      .reg_enable(reg_enable), .reg_load(reg_load), .reg_mode(reg_mode),
      .reg_parallel_in(reg_parallel_in), .busy(busy),
      .fault_count(fault_count), .fault_count_clr(fault_count_clr)
   );

   // Narrow-counter instance used only for saturation.
   tmr_shift_ctrl #(.width(W), .cnt_width(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .tx_valid(1'b0), .tx_ready(d3_tx_ready), .tx_data('0),
      .tx_bit_valid(d3_tx_bit_valid),
      .rx_req(1'b0), .rx_bit_strobe(d3_rx_bit_strobe), .rx_valid(d3_rx_valid), .rx_data(d3_rx_data),
      .reg_parallel_out('0),
      .fault_1(fault_1), .fault_2(fault_2), .fault_3(fault_3),
      .reg_enable(d3_reg_enable), .reg_load(d3_reg_load), .reg_mode(d3_reg_mode),
      .reg_parallel_in(d3_reg_parallel_in), .busy(d3_busy),
      .fault_count(d3_fault_count), .fault_count_clr(fault_count_clr)
   );

   // Behavioural TMR register (single copy standing in for the voted value).
   always @(posedge clk) begin
      if (rst) begin
         reg_q <= '0;
      end else if (reg_enable) begin
         if (reg_load) begin
            reg_q <= reg_parallel_in;
         end else begin
            case (reg_mode)
               2'b00:   reg_q <= {serial_in, reg_q[W-1:1]};
               2'b01:   reg_q <= {reg_q[W-2:0], serial_in};
               2'b10:   reg_q <= {1'b0, reg_q[W-1:1]};
               default: reg_q <= reg_parallel_in;
            endcase
         end
      end
   end

   assign serial_out       = reg_q[0];
   assign reg_parallel_out = reg_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic wait_idle;
      for (int i = 0; i < 300; i++) begin
         if (tx_ready === 1'b1 && busy === 1'b0) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (reg_mode !== 2'b11) begin errors++; $display("FAIL reset_mode: got %b exp 11", reg_mode); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (fault_count !== 16'd0) begin errors++; $display("FAIL reset_fault_count: got %0d exp 0", fault_count); end
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_tx_ready: got %b exp 0", tx_ready); end
      checks++; if ({reg_enable, reg_load, tx_bit_valid, rx_bit_strobe, rx_valid} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b exp 00000", {reg_enable, reg_load, tx_bit_valid, rx_bit_strobe, rx_valid});
      end
      checks++; if (reg_parallel_in !== '0 || rx_data !== '0) begin
         errors++; $display("FAIL reset_data: got %h/%h exp 0/0", reg_parallel_in, rx_data);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", tx_ready); end
   endtask

   task automatic test_tx;
      logic [W-1:0] got;
      int first, last, nb;
      logic rdy65, rdy66;
      wait_idle();
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_idle: got %b exp 1", tx_ready); end
      tx_data = TXW; tx_valid = 1'b1;
      got = '0; nb = 0; first = -1; last = -1; rdy65 = 1'bx; rdy66 = 1'bx;
      for (int c = 1; c <= 68; c++) begin
         @(negedge clk);
         if (c == 1) begin
            tx_valid = 1'b0;
            checks++; if ({reg_load, reg_enable, reg_mode} !== 4'b1110) begin
               errors++; $display("FAIL tx_load_ctrl: got %b exp 1110", {reg_load, reg_enable, reg_mode});
            end
            checks++; if (reg_parallel_in !== TXW) begin errors++; $display("FAIL tx_par_in: got %h exp %h", reg_parallel_in, TXW); end
         end
         if (tx_bit_valid) begin
            if (first < 0) first = c;
            last = c;
            got = {serial_out, got[W-1:1]};
            nb++;
         end
         if (c == 65) rdy65 = tx_ready;
         if (c == 66) rdy66 = tx_ready;
      end
      checks++; if (first != 2) begin errors++; $display("FAIL tx_first_bit: got %0d exp 2", first); end
      checks++; if (last != 65) begin errors++; $display("FAIL tx_last_bit: got %0d exp 65", last); end
      checks++; if (nb != 64) begin errors++; $display("FAIL tx_bit_count: got %0d exp 64", nb); end
      checks++; if (got !== TXW) begin errors++; $display("FAIL tx_word: got %h exp %h", got, TXW); end
      checks++; if (rdy65 !== 1'b0 || rdy66 !== 1'b1) begin
         errors++; $display("FAIL tx_ready_return: got %b%b exp 01", rdy65, rdy66);
      end
   endtask

   task automatic test_rx;
      logic [W-1:0] sh, vd, hold;
      int fs, ns, nv, vc;
      logic rdy66;
      wait_idle();
      rx_req = 1'b1; sh = RXW;
      fs = -1; ns = 0; nv = 0; vc = -1; vd = '0; hold = '0; rdy66 = 1'bx;
      for (int c = 1; c <= 68; c++) begin
         @(negedge clk);
         if (c == 1) begin
            rx_req = 1'b0;
            checks++; if ({busy, reg_enable, reg_mode} !== 4'b1100) begin
               errors++; $display("FAIL rx_shift_ctrl: got %b exp 1100", {busy, reg_enable, reg_mode});
            end
         end
         if (rx_bit_strobe) begin
            if (fs < 0) fs = c;
            serial_in = sh[0];
            sh = sh >> 1;
            ns++;
         end
         if (rx_valid) begin nv++; vc = c; vd = rx_data; end
         if (c == 66) rdy66 = tx_ready;
         if (c == 67) hold = rx_data;
      end
      checks++; if (fs != 1 || ns != 64) begin errors++; $display("FAIL rx_strobes: got first %0d n %0d exp 1/64", fs, ns); end
      checks++; if (nv != 1 || vc != 65) begin errors++; $display("FAIL rx_valid_pulse: got n %0d at %0d exp 1 at 65", nv, vc); end
      checks++; if (vd !== RXW) begin errors++; $display("FAIL rx_word: got %h exp %h", vd, RXW); end
      checks++; if (hold !== RXW) begin errors++; $display("FAIL rx_data_hold: got %h exp %h", hold, RXW); end
      checks++; if (rdy66 !== 1'b1) begin errors++; $display("FAIL rx_ready_return: got %b exp 1", rdy66); end
   endtask

   task automatic test_arbitration;
      logic [W-1:0] got, sh, vd;
      int ftx, fs, vc;
      wait_idle();
      tx_data = ARB_TX; tx_valid = 1'b1; rx_req = 1'b1; sh = ARB_RX;
      got = '0; ftx = -1; fs = -1; vc = -1; vd = '0;
      for (int c = 1; c <= 135; c++) begin
         @(negedge clk);
         if (c == 1) tx_valid = 1'b0;
         if (tx_bit_valid) begin
            if (ftx < 0) ftx = c;
            got = {serial_out, got[W-1:1]};
         end
         if (rx_bit_strobe) begin
            if (fs < 0) fs = c;
            rx_req = 1'b0;
            serial_in = sh[0];
            sh = sh >> 1;
         end
         if (rx_valid) begin vc = c; vd = rx_data; end
      end
      rx_req = 1'b0;
      checks++; if (ftx != 2) begin errors++; $display("FAIL arb_tx_first: got %0d exp 2", ftx); end
      checks++; if (got !== ARB_TX) begin errors++; $display("FAIL arb_tx_word: got %h exp %h", got, ARB_TX); end
      checks++; if (fs != 67) begin errors++; $display("FAIL arb_rx_start: got %0d exp 67", fs); end
      checks++; if (vc != 131 || vd !== ARB_RX) begin
         errors++; $display("FAIL arb_rx_word: got %h at %0d exp %h at 131", vd, vc, ARB_RX);
      end
   endtask

   task automatic test_fault;
      @(negedge clk);
      fault_count_clr = 1'b1;
      @(negedge clk);
      fault_count_clr = 1'b0;
      checks++; if (fault_count !== 16'd0 || d3_fault_count !== 3'd0) begin
         errors++; $display("FAIL fault_clear_start: got %0d/%0d exp 0/0", fault_count, d3_fault_count);
      end
      fault_2 = 1'b1;
      repeat (5) @(negedge clk);
      fault_2 = 1'b0;
      checks++; if (fault_count !== 16'd5 || d3_fault_count !== 3'd5) begin
         errors++; $display("FAIL fault_count_5: got %0d/%0d exp 5/5", fault_count, d3_fault_count);
      end
      @(negedge clk);
      checks++; if (fault_count !== 16'd5) begin errors++; $display("FAIL fault_idle_hold: got %0d exp 5", fault_count); end
      fault_1 = 1'b1;
      repeat (5) @(negedge clk);
      fault_1 = 1'b0;
      checks++; if (fault_count !== 16'd10) begin errors++; $display("FAIL fault_count_10: got %0d exp 10", fault_count); end
      checks++; if (d3_fault_count !== 3'd7) begin errors++; $display("FAIL fault_saturate: got %0d exp 7", d3_fault_count); end
      fault_3 = 1'b1; fault_count_clr = 1'b1;
      @(negedge clk);
      fault_3 = 1'b0; fault_count_clr = 1'b0;
      checks++; if (fault_count !== 16'd0 || d3_fault_count !== 3'd0) begin
         errors++; $display("FAIL fault_clr_priority: got %0d/%0d exp 0/0", fault_count, d3_fault_count);
      end
   endtask

   task automatic test_mid_reset;
      int ntx, nrx, nst;
      wait_idle();
      tx_data = TXW; tx_valid = 1'b1;
      ntx = 0; nrx = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c == 1) tx_valid = 1'b0;
         if (c == 32) rst = 1'b1;
         if (c == 33) begin
            rst = 1'b0;
            checks++; if ({busy, tx_bit_valid, reg_enable, reg_mode} !== 5'b00011) begin
               errors++; $display("FAIL tx_abort_state: got %b exp 00011", {busy, tx_bit_valid, reg_enable, reg_mode});
            end
         end
         if (c == 34) begin
            checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_abort_ready: got %b exp 1", tx_ready); end
         end
         if (c >= 33 && tx_bit_valid) ntx++;
         if (rx_valid) nrx++;
      end
      checks++; if (ntx != 0 || nrx != 0) begin errors++; $display("FAIL tx_abort_quiet: got %0d/%0d exp 0/0", ntx, nrx); end
      wait_idle();
      rx_req = 1'b1; serial_in = 1'b1;
      nrx = 0; nst = 0;
      for (int c = 1; c <= 90; c++) begin
         @(negedge clk);
         if (c == 1) rx_req = 1'b0;
         if (c == 20) rst = 1'b1;
         if (c == 21) begin
            rst = 1'b0;
            checks++; if ({busy, rx_bit_strobe} !== 2'b00) begin
               errors++; $display("FAIL rx_abort_state: got %b exp 00", {busy, rx_bit_strobe});
            end
         end
         if (c >= 21 && rx_bit_strobe) nst++;
         if (rx_valid) nrx++;
      end
      serial_in = 1'b0;
      checks++; if (nst != 0 || nrx != 0) begin errors++; $display("FAIL rx_abort_quiet: got %0d/%0d exp 0/0", nst, nrx); end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] g0, g1;
      int n, nb, nrdy;
      int acc[2];
      wait_idle();
      g0 = '0; g1 = '0; n = 0; nb = 0; nrdy = 0; acc[0] = -1; acc[1] = -1;
      for (int c = 0; c <= 140; c++) begin
         if (c > 0) @(negedge clk);
         if (tx_bit_valid) begin
            if (nb < 64) g0 = {serial_out, g0[W-1:1]};
            else g1 = {serial_out, g1[W-1:1]};
            nb++;
         end
         if (c >= 1 && c <= 131 && tx_ready) nrdy++;
         if (tx_ready) begin
            if (n < 2) begin
               tx_data  = (n == 0) ? B0 : B1;
               tx_valid = 1'b1;
               acc[n]   = c;
               n++;
            end else begin
               tx_valid = 1'b0;
            end
         end
      end
      tx_valid = 1'b0;
      checks++; if (n != 2 || acc[1] - acc[0] != 66) begin
         errors++; $display("FAIL b2b_period: got %0d words spacing %0d exp 2 words spacing 66", n, acc[1] - acc[0]);
      end
      checks++; if (nrdy != 1) begin errors++; $display("FAIL b2b_idle_cycles: got %0d exp 1", nrdy); end
      checks++; if (nb != 128) begin errors++; $display("FAIL b2b_bits: got %0d exp 128", nb); end
      checks++; if (g0 !== B0 || g1 !== B1) begin
         errors++; $display("FAIL b2b_words: got %h %h exp %h %h", g0, g1, B0, B1);
      end
   endtask

   initial begin
      rst = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_req = 1'b0; serial_in = 1'b0;
      fault_1 = 1'b0; fault_2 = 1'b0; fault_3 = 1'b0; fault_count_clr = 1'b0;
      test_reset();
      test_tx();
      test_rx();
      test_arbitration();
      test_fault();
      test_mid_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tmr_shift_ctrl.md
# tmr_shift_ctrl

Sequencing controller for the 64-bit TMR shift register. Accepts whole words from a valid/ready producer and drives them out serially through the register's PISO mode. Captures serial words through SISO-right mode and returns them as a parallel strobe. It owns the register's `mode`, `load`, `enable` and `parallel_in`, and keeps a saturating count of replica-fault cycles reported by the TMR fault flags.

## Interface

Parameters:
- `width`, default 64: register width; must be ≥ 2.
- `cnt_width`, default 16: fault counter width.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `tx_valid`  in  1  producer has a word.
- `tx_ready`  out  1  controller accepts a tx word or rx request this cycle.
- `tx_data`  in  width  word to serialize.
- `tx_bit_valid`  out  1  register `serial_out` carries a valid tx bit this cycle.
- `rx_req`  in  1  request to capture one serial word.
- `rx_bit_strobe`  out  1  upstream must present a valid `serial_in` this cycle.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` valid.
- `rx_data`  out  width  captured word.
- `reg_parallel_out`  in  width  voted parallel output of the TMR register.
- `fault_1`, `fault_2`, `fault_3`  in  1 each  replica mismatch flags.
- `reg_enable`  out  1  register enable.
- `reg_load`  out  1  register load.
- `reg_mode`  out  2  register mode.
- `reg_parallel_in`  out  width  register parallel input.
- `busy`  out  1  state ≠ IDLE.
- `fault_count`  out  cnt_width  saturating fault-cycle count.
- `fault_count_clr`  in  1  synchronous clear of `fault_count`.

## Operation

States are IDLE, TX_LOAD, TX_SHIFT, RX_SHIFT and RX_DONE. `bit_cnt` is `$clog2(width)` bits wide.

- **IDLE**
  - Outputs: `tx_ready`=1, `reg_enable`=0, `reg_load`=0, `reg_mode`=PIPO (2'b11).
  - `tx_valid` high: the word is latched into `reg_parallel_in` and the next state is TX_LOAD.
  - `rx_req` high with `tx_valid` low: the next state is RX_SHIFT.
  - Both high: tx wins, and `rx_req` stays pending (it is a level request).
- **TX_LOAD** (one cycle)
  - Outputs: `reg_mode`=PISO (2'b10), `reg_load`=1, `reg_enable`=1.
  - Clears `bit_cnt`.
- **TX_SHIFT** (exactly `width` cycles)
  - Outputs: `reg_mode`=PISO, `reg_load`=0, `reg_enable`=1, `tx_bit_valid`=1.
  - The bit on `serial_out` in a given cycle is `tx_data[bit_cnt]`, LSB first.
  - When `bit_cnt`==width-1, the next state is IDLE.
- **RX_SHIFT** (exactly `width` cycles)
  - Outputs: `reg_mode`=SISO-right (2'b00), `reg_enable`=1, `rx_bit_strobe`=1.
  - The upstream bit sampled in the cycle where `bit_cnt`=k lands at `rx_data[k]`, so bits arrive LSB first.
  - When `bit_cnt`==width-1, the next state is RX_DONE.
- **RX_DONE** (one cycle)
  - Outputs: `reg_enable`=0, `rx_valid`=1, `rx_data`=`reg_parallel_out`.
  - rx has no backpressure.
  - Next state is IDLE.
- **Fault counter**
  - Increments once per cycle in which any `fault_i` is high, in any state.
  - Saturates at 2^cnt_width−1 and does not wrap.
  - `fault_count_clr` has priority over increment; a simultaneous clear and fault gives 0.

## Timing

- **Reset values:** state=IDLE, `tx_ready`=0 during the reset cycle and 1 after, all other 1-bit outputs 0, `reg_mode`=2'b11, `reg_parallel_in`=0, `rx_data`=0, `fault_count`=0.
- **Reset mid-operation:** at the next edge the controller aborts to IDLE. No partial `rx_valid` is produced. Register contents are left to the register's own reset.
- **Tx latency:** the handshake occurs in cycle t. Bit 0 appears on `serial_out` at t+2. The last bit appears at t+1+width. `tx_ready` returns at t+2+width.
- **Rx latency:** `rx_req` is accepted at t. Strobes run from t+1 to t+width. `rx_valid` is at t+width+1. `tx_ready` returns at t+width+2.
- **Output decoding:** all register-control outputs are decoded from the state register only. There is no combinational path from `tx_valid` or `rx_req` to `reg_*`. `tx_ready` is state-only.
- **Back-to-back:** `tx_valid` held high gives one word per width+2 cycles, with no bubble beyond the IDLE cycle.

## Structure

- Package `tmr_ctrl_pkg` holds:
  - the `state_t` enum;
  - the constants `MODE_SISO_R`=2'b00, `MODE_SISO_L`=2'b01, `MODE_PISO`=2'b10, `MODE_PIPO`=2'b11.
- Sub-module `fault_counter` (parameter `cnt_width`) contains the saturating counter: inputs are `clk`, `rst`, `inc`, `clr`.
- Everything else lives in a single FSM module. The bench instantiates it together with the TMR register.

## Test plan

- **Reset:** assert `rst` for 2 cycles → `reg_mode`=2'b11, `busy`=0, `fault_count`=0, `tx_ready`=1 the cycle after release.
- **Tx:** `tx_data`=64'hA5A5_0000_FFFF_1234 accepted at t → `tx_bit_valid` high for cycles t+2..t+65; the serial bits, collected LSB first, rebuild 64'hA5A5_0000_FFFF_1234; `tx_ready` is high at t+66.
- **Rx:** `rx_req` with `serial_in` driven from 64'h0123_4567_89AB_CDEF, LSB first, on each strobe → a single `rx_valid` pulse with `rx_data`=64'h0123_4567_89AB_CDEF.
- **Arbitration:** `tx_valid` and `rx_req` both high in IDLE → tx is served first; rx starts in the cycle after tx returns to IDLE.
- **Fault counting:** force `fault_2`=1 for 5 cycles → `fault_count`=5. With `cnt_width`=3, force 10 fault cycles → 7. Pulse `fault_count_clr` together with a fault → 0.
- **Mid-operation reset:** assert `rst` at bit 30 of a tx → IDLE the next cycle, with no further `tx_bit_valid` and no `rx_valid`.
